// File: rtl/ahblite_busmatrix_inputstage_dtcm.sv
// Per-master input stage on the DTCM path of the AHB-lite bus matrix.
// Requests the DTCM arbiter, parks the address phase while ungranted and stalls the master until DTCM completes.
module ahblite_busmatrix_inputstage_dtcm #(
    parameter logic [1:0] PORT_ID    = 2'b01,
    parameter int         ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic                  REQ_DTCM,
    input  logic [1:0]            PORT_SEL_ARBITER_DTCM,
    input  logic                  PORT_NOSEL_ARBITER_DTCM,
    input  logic                  HREADY_Outputstage_DTCM,
    input  logic                  HRESP_Outputstage_DTCM,
    output logic                  HSEL_Inputstage,
    output logic [ADDR_WIDTH-1:0] HADDR_Inputstage,
    output logic [1:0]            HTRANS_Inputstage,
    output logic                  HWRITE_Inputstage,
    output logic [2:0]            HSIZE_Inputstage,
    output logic [2:0]            HBURST_Inputstage,
    output logic [3:0]            HPROT_Inputstage
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_DATA
    } state_t;

    state_t state, state_next;

    logic                  granted;
    logic                  new_trans;
    logic                  issue_ok;
    logic [ADDR_WIDTH-1:0] held_addr;
    logic [1:0]            held_trans;
    logic                  held_write;
    logic [2:0]            held_size;
    logic [2:0]            held_burst;
    logic [3:0]            held_prot;

    assign granted   = (PORT_SEL_ARBITER_DTCM == PORT_ID) && !PORT_NOSEL_ARBITER_DTCM;
    assign new_trans = HSEL && HREADY && HTRANS[1];
    assign issue_ok  = granted && HREADY_Outputstage_DTCM;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Only transfers that cannot go straight to the output stage are parked here
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            held_addr  <= '0;
            held_trans <= 2'b00;
            held_write <= 1'b0;
            held_size  <= 3'b000;
            held_burst <= 3'b000;
            held_prot  <= 4'b0000;
        end else if (new_trans && !issue_ok) begin
            held_addr  <= HADDR;
            held_trans <= HTRANS;
            held_write <= HWRITE;
            held_size  <= HSIZE;
            held_burst <= HBURST;
            held_prot  <= HPROT;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (new_trans) begin
                    state_next = issue_ok ? ST_DATA : ST_PEND;
                end
            end
            ST_PEND: begin
                if (issue_ok) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                // Completion cycle doubles as the next address phase
                if (HREADY_Outputstage_DTCM) begin
                    if (new_trans) begin
                        state_next = issue_ok ? ST_DATA : ST_PEND;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        HREADYOUT         = 1'b1;
        HRESP             = 1'b0;
        HSEL_Inputstage   = HSEL;
        HADDR_Inputstage  = HADDR;
        HTRANS_Inputstage = HSEL ? HTRANS : 2'b00;
        HWRITE_Inputstage = HWRITE;
        HSIZE_Inputstage  = HSIZE;
        HBURST_Inputstage = HBURST;
        HPROT_Inputstage  = HPROT;
        case (state)
            ST_PEND: begin
                HREADYOUT         = 1'b0;
                HSEL_Inputstage   = 1'b1;
                HADDR_Inputstage  = held_addr;
                HTRANS_Inputstage = held_trans;
                HWRITE_Inputstage = held_write;
                HSIZE_Inputstage  = held_size;
                HBURST_Inputstage = held_burst;
                HPROT_Inputstage  = held_prot;
            end
            ST_DATA: begin
                HREADYOUT = HREADY_Outputstage_DTCM;
                HRESP     = HRESP_Outputstage_DTCM;
            end
            default: begin
            end
        endcase
        // Keep the arbiter and output stage quiet while reset is held
        if (HRESET) begin
            HSEL_Inputstage   = 1'b0;
            HTRANS_Inputstage = 2'b00;
        end
        REQ_DTCM = !HRESET && ((state == ST_PEND) || (HSEL && (HTRANS != 2'b00)));
    end

endmodule

// File: tb/tb_ahblite_busmatrix_inputstage_dtcm.sv
// Scoreboard bench for the DTCM input stage: directed timing cases, then randomized master/arbiter/DTCM traffic.
module tb_ahblite_busmatrix_inputstage_dtcm;

    localparam logic [1:0] PORT_ID = 2'b01;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'd2;
    logic [2:0]  HBURST = 3'd0;
    logic [3:0]  HPROT = 4'd3;
    wire         HREADY;
    logic        HREADYOUT, HRESP, REQ_DTCM;
    logic [1:0]  PORT_SEL_ARBITER_DTCM = 2'b00;
    logic        PORT_NOSEL_ARBITER_DTCM = 1'b1;
    logic        HREADY_Outputstage_DTCM = 1'b1;
    logic        HRESP_Outputstage_DTCM = 1'b0;
    logic        HSEL_Inputstage;
    logic [31:0] HADDR_Inputstage;
    logic [1:0]  HTRANS_Inputstage;
    logic        HWRITE_Inputstage;
    logic [2:0]  HSIZE_Inputstage, HBURST_Inputstage;
    logic [3:0]  HPROT_Inputstage;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
    } xfer_t;

    xfer_t exp_q[$];
    logic  in_data = 1'b0;
    int    checks = 0;
    int    errors = 0;

    assign HREADY = HREADYOUT;

    ahblite_busmatrix_inputstage_dtcm #(.PORT_ID(PORT_ID), .ADDR_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .REQ_DTCM(REQ_DTCM),
        .PORT_SEL_ARBITER_DTCM(PORT_SEL_ARBITER_DTCM), .PORT_NOSEL_ARBITER_DTCM(PORT_NOSEL_ARBITER_DTCM),
        .HREADY_Outputstage_DTCM(HREADY_Outputstage_DTCM), .HRESP_Outputstage_DTCM(HRESP_Outputstage_DTCM),
        .HSEL_Inputstage(HSEL_Inputstage), .HADDR_Inputstage(HADDR_Inputstage),
        .HTRANS_Inputstage(HTRANS_Inputstage), .HWRITE_Inputstage(HWRITE_Inputstage),
        .HSIZE_Inputstage(HSIZE_Inputstage), .HBURST_Inputstage(HBURST_Inputstage),
        .HPROT_Inputstage(HPROT_Inputstage)
    );

    always #5 HCLK = ~HCLK;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                                 input logic wr, input logic [1:0] gsel, input logic nosel,
                                 input logic rdy, input logic resp);
        HSEL = sel;
        HTRANS = trans;
        HADDR = addr;
        HWRITE = wr;
        PORT_SEL_ARBITER_DTCM = gsel;
        PORT_NOSEL_ARBITER_DTCM = nosel;
        HREADY_Outputstage_DTCM = rdy;
        HRESP_Outputstage_DTCM = resp;
    endtask

    task automatic checkPort(input string name, input logic e_rdy, input logic e_resp,
                             input logic e_req, input logic [1:0] e_trans);
        checkOutput({name, "_hreadyout"}, 64'(HREADYOUT), 64'(e_rdy));
        checkOutput({name, "_hresp"}, 64'(HRESP), 64'(e_resp));
        checkOutput({name, "_req"}, 64'(REQ_DTCM), 64'(e_req));
        checkOutput({name, "_htrans_in"}, 64'(HTRANS_Inputstage), 64'(e_trans));
    endtask

    // One directed cycle: drive after the edge, check mid-cycle, advance to the next edge
    task automatic stepCheck(input string name, input logic sel, input logic [1:0] trans,
                             input logic [31:0] addr, input logic wr, input logic [1:0] gsel,
                             input logic nosel, input logic rdy, input logic resp,
                             input logic e_rdy, input logic e_resp, input logic e_req,
                             input logic [1:0] e_trans);
        applyStimulus(sel, trans, addr, wr, gsel, nosel, rdy, resp);
        @(negedge HCLK);
        checkPort(name, e_rdy, e_resp, e_req, e_trans);
        @(posedge HCLK);
        #1;
    endtask

    // Every address phase the master gets accepted must later be issued to DTCM exactly once
    always @(negedge HCLK) begin
        xfer_t x;
        #1;
        if (!HRESET && HSEL && HREADY && HTRANS[1]) begin
            x.addr = HADDR;
            x.trans = HTRANS;
            x.write = HWRITE;
            x.size = HSIZE;
            x.burst = HBURST;
            x.prot = HPROT;
            exp_q.push_back(x);
        end
    end

    // Transaction-level model: a waiting transfer stalls the master; an issued one passes DTCM ready/response
    always begin
        logic  pend, e_rdy, e_resp, e_req, grant_now, act_issue, exp_issue;
        xfer_t x;
        @(negedge HCLK);
        if (!HRESET) begin
            pend = (exp_q.size() > 0);
            e_rdy = pend ? 1'b0 : (in_data ? HREADY_Outputstage_DTCM : 1'b1);
            e_resp = (!pend && in_data) ? HRESP_Outputstage_DTCM : 1'b0;
            e_req = pend || (HSEL && (HTRANS != 2'b00));
            checkOutput("mon_hreadyout", 64'(HREADYOUT), 64'(e_rdy));
            checkOutput("mon_hresp", 64'(HRESP), 64'(e_resp));
            checkOutput("mon_req", 64'(REQ_DTCM), 64'(e_req));
            #2;
            if (!HRESET) begin
                grant_now = (PORT_SEL_ARBITER_DTCM == PORT_ID) && !PORT_NOSEL_ARBITER_DTCM;
                act_issue = grant_now && HREADY_Outputstage_DTCM && HSEL_Inputstage && HTRANS_Inputstage[1];
                exp_issue = grant_now && HREADY_Outputstage_DTCM && (exp_q.size() > 0);
                checkOutput("mon_issue", 64'(act_issue), 64'(exp_issue));
                if (act_issue) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("mon_unexpected_issue_addr", 64'(HADDR_Inputstage), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        x = exp_q.pop_front();
                        checkOutput("issue_haddr", 64'(HADDR_Inputstage), 64'(x.addr));
                        checkOutput("issue_htrans", 64'(HTRANS_Inputstage), 64'(x.trans));
                        checkOutput("issue_hwrite", 64'(HWRITE_Inputstage), 64'(x.write));
                        checkOutput("issue_hsize", 64'(HSIZE_Inputstage), 64'(x.size));
                        checkOutput("issue_hburst", 64'(HBURST_Inputstage), 64'(x.burst));
                        checkOutput("issue_hprot", 64'(HPROT_Inputstage), 64'(x.prot));
                    end
                    in_data = 1'b1;
                end else if (in_data && HREADY_Outputstage_DTCM) begin
                    in_data = 1'b0;
                end
            end
        end
    end

    initial begin
        logic       last_hready, last_rdy, err_phase;
        int         r;

        // Reset with a live NONSEQ on the master side
        applyStimulus(1'b1, 2'b10, 32'h2000_0010, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        checkPort("reset", 1'b1, 1'b0, 1'b0, 2'b00);
        checkOutput("reset_hsel_in", 64'(HSEL_Inputstage), 64'd0);
        applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        #3 HRESET = 1'b0;
        @(posedge HCLK);
        #1;

        // Grant already held, zero-wait
        stepCheck("g_addr", 1, 2'b10, 32'h2000_0010, 1, 2'b01, 0, 1, 0, 1, 0, 1, 2'b10);
        stepCheck("g_data", 0, 2'b00, 32'h0, 0, 2'b01, 0, 1, 0, 1, 0, 0, 2'b00);

        // No owner: capture, grant, one wait state
        stepCheck("ng_cap", 1, 2'b10, 32'h2000_0040, 0, 2'b00, 1, 1, 0, 1, 0, 1, 2'b10);
        stepCheck("ng_issue", 0, 2'b00, 32'h0, 0, 2'b01, 0, 1, 0, 0, 0, 1, 2'b10);
        stepCheck("ng_done", 0, 2'b00, 32'h0, 0, 2'b01, 0, 1, 0, 1, 0, 0, 2'b00);

        // DMA owns DTCM through an INCR4 burst; our transfer waits
        stepCheck("dma_cap", 1, 2'b10, 32'h2000_0080, 1, 2'b10, 0, 0, 0, 1, 0, 1, 2'b10);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 2'b00, 32'h0, 0, 2'b10, 0, 1'(i % 2), 0);
            @(negedge HCLK);
            checkPort("dma_pend", 0, 0, 1, 2'b10);
            checkOutput("dma_pend_haddr", 64'(HADDR_Inputstage), 64'h2000_0080);
            @(posedge HCLK);
            #1;
        end
        stepCheck("dma_issue", 0, 2'b00, 32'h0, 0, 2'b01, 0, 1, 0, 0, 0, 1, 2'b10);
        stepCheck("dma_done", 0, 2'b00, 32'h0, 0, 2'b01, 0, 1, 0, 1, 0, 0, 2'b00);

        // Two-cycle ERROR, master cancels, then a normal transfer
        stepCheck("err_addr", 1, 2'b10, 32'h2000_00C0, 0, 2'b01, 0, 1, 0, 1, 0, 1, 2'b10);
        stepCheck("err_c1", 1, 2'b00, 32'h0, 0, 2'b01, 0, 0, 1, 0, 1, 0, 2'b00);
        stepCheck("err_c2", 1, 2'b00, 32'h0, 0, 2'b01, 0, 1, 1, 1, 1, 0, 2'b00);
        stepCheck("err_next", 1, 2'b10, 32'h2000_0100, 1, 2'b01, 0, 1, 0, 1, 0, 1, 2'b10);
        stepCheck("err_done", 0, 2'b00, 32'h0, 0, 2'b01, 0, 1, 0, 1, 0, 0, 2'b00);

        // Back-to-back: the stall in the third cycle shows the second transfer is in its data phase
        stepCheck("b2b_a0", 1, 2'b10, 32'h2000_0000, 1, 2'b01, 0, 1, 0, 1, 0, 1, 2'b10);
        stepCheck("b2b_a1", 1, 2'b10, 32'h2000_0004, 1, 2'b01, 0, 1, 0, 1, 0, 1, 2'b10);
        stepCheck("b2b_wait", 0, 2'b00, 32'h0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00);
        stepCheck("b2b_done", 0, 2'b00, 32'h0, 0, 2'b01, 0, 1, 0, 1, 0, 0, 2'b00);

        // Reset while parked; the stale address must never reach DTCM
        stepCheck("rst_cap", 1, 2'b10, 32'h2000_0200, 1, 2'b10, 0, 0, 0, 1, 0, 1, 2'b10);
        applyStimulus(0, 2'b00, 32'h0, 0, 2'b10, 0, 0, 0);
        @(negedge HCLK);
        checkPort("rst_pend", 0, 0, 1, 2'b10);
        #3 HRESET = 1'b1;
        #1;
        checkPort("rst_async", 1, 0, 0, 2'b00);
        checkOutput("rst_async_hsel_in", 64'(HSEL_Inputstage), 64'd0);
        exp_q.delete();
        in_data = 1'b0;
        @(posedge HCLK);
        #1;
        applyStimulus(0, 2'b00, 32'h0, 0, 2'b01, 0, 1, 0);
        @(negedge HCLK);
        #3 HRESET = 1'b0;
        @(posedge HCLK);
        #1;
        for (int i = 0; i < 3; i++) begin
            stepCheck("rst_after", 0, 2'b00, 32'h0, 0, 2'b01, 0, 1, 0, 1, 0, 0, 2'b00);
        end

        // Randomized traffic: master holds while stalled, grant moves only on DTCM ready
        err_phase = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge HCLK);
            last_hready = HREADY;
            last_rdy = HREADY_Outputstage_DTCM;
            @(posedge HCLK);
            #1;
            if (err_phase) begin
                HREADY_Outputstage_DTCM = 1'b1;
                HRESP_Outputstage_DTCM = 1'b1;
                err_phase = 1'b0;
            end else begin
                r = $urandom_range(99, 0);
                HRESP_Outputstage_DTCM = (r < 8);
                HREADY_Outputstage_DTCM = (r >= 38);
                err_phase = (r < 8);
            end
            if (last_rdy) begin
                r = $urandom_range(99, 0);
                PORT_NOSEL_ARBITER_DTCM = (r >= 85);
                PORT_SEL_ARBITER_DTCM = (r < 50) ? 2'b01 : (r < 70) ? 2'b10 : (r < 85) ? 2'b11 : 2'b00;
            end
            if (last_hready) begin
                HSEL = ($urandom_range(99, 0) < 75);
                HTRANS = 2'($urandom_range(3, 0));
                HADDR = 32'h2000_0000 | ($urandom & 32'h0000_FFFC);
                HWRITE = 1'($urandom_range(1, 0));
                HSIZE = 3'($urandom_range(2, 0));
                HBURST = 3'($urandom_range(7, 0));
                HPROT = 4'($urandom_range(15, 0));
            end
        end

        // Drain: grant ourselves with a zero-wait DTCM so anything parked completes
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 2'b00, 32'h0, 0, 2'b01, 0, 1, 0);
            @(posedge HCLK);
            #1;
        end
        @(negedge HCLK);
        #3;
        checkOutput("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        checkPort("drain_idle", 1, 0, 0, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahblite_busmatrix_inputstage_dtcm.md
# ahblite_busmatrix_inputstage_dtcm

Per-master input stage on the DTCM path of the AHB-lite bus matrix; it is the requesting end of the DTCM arbiter's REQ/grant handshake. It accepts address phases from one master (SYS, DMA or ACC), raises the request toward the DTCM arbiter and holds the transfer in a register while the port is granted elsewhere. It stalls the master with HREADYOUT until the transfer has been issued to and completed by the DTCM output stage. One instance per master, distinguished by PORT_ID.

## Interface
- PORT_ID, 2'b01, grant code that means "this master owns DTCM" (01 SYS, 10 DMA, 11 ACC)
- ADDR_WIDTH, 32, HADDR width
- HCLK  in  1  bus clock; all state updates on rising edge
- HRESET  in  1  asynchronous, active-high reset
- HSEL  in  1  master-side decode hit for DTCM region
- HADDR  in  ADDR_WIDTH  master address
- HTRANS  in  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- HWRITE  in  1; HSIZE  in  3; HBURST  in  3; HPROT  in  4  master address-phase controls
- HREADY  in  1  bus-level ready seen by the master
- HREADYOUT  out  1  ready returned to the master
- HRESP  out  1  response returned to the master
- REQ_DTCM  out  1  request to DTCM arbiter
- PORT_SEL_ARBITER_DTCM  in  2  registered grant code from arbiter
- PORT_NOSEL_ARBITER_DTCM  in  1  arbiter reports no owner
- HREADY_Outputstage_DTCM  in  1  DTCM data-phase ready
- HRESP_Outputstage_DTCM  in  1  DTCM response
- HSEL_Inputstage, HADDR_Inputstage, HTRANS_Inputstage, HWRITE_Inputstage, HSIZE_Inputstage, HBURST_Inputstage, HPROT_Inputstage  out  1/ADDR_WIDTH/2/1/3/3/4  address phase offered to the DTCM output stage

## Operation
- granted = (PORT_SEL_ARBITER_DTCM == PORT_ID) & ~PORT_NOSEL_ARBITER_DTCM.
- new_trans = HSEL & HREADY & HTRANS[1].
- Holding register captures HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT on new_trans & ~(granted & HREADY_Outputstage_DTCM).
- States: IDLE, PEND (held address awaiting grant), DATA (address issued, awaiting DTCM data phase).
- IDLE: HREADYOUT=1, HRESP=0. new_trans & granted & HREADY_Outputstage_DTCM -> DATA (live signals forwarded). new_trans otherwise -> PEND (captured).
- PEND: HREADYOUT=0, HRESP=0, outputs driven from holding register with HSEL_Inputstage=1. granted & HREADY_Outputstage_DTCM -> DATA.
- DATA: HREADYOUT=HREADY_Outputstage_DTCM, HRESP=HRESP_Outputstage_DTCM. On HREADY_Outputstage_DTCM=1, the data phase ends and IDLE-state decoding of new_trans applies in the same cycle (back-to-back transfers). Otherwise stay in DATA.
- Outside PEND, outputs forward live master signals. HSEL_Inputstage = HSEL; HTRANS_Inputstage is forced to IDLE unless state ∈ {IDLE, DATA} with HSEL=1.
- REQ_DTCM = (state==PEND) | (HSEL & HTRANS!=IDLE). BUSY/SEQ beats keep the request high so a burst keeps the grant.
- Two-cycle ERROR: the first ERROR cycle (HREADYOUT=0, HRESP=1) and the second (HREADYOUT=1, HRESP=1) both pass through from the output stage. If the master cancels with HTRANS=IDLE, no new PEND is created.
- new_trans while in PEND or DATA with HREADYOUT=0 cannot occur (HREADY low). The block does not guard against it.

## Timing
- Reset (HRESET=1, async): state=IDLE, holding register=0, HREADYOUT=1, HRESP=0, REQ_DTCM=0, HTRANS_Inputstage=00, HSEL_Inputstage=0. Deassertion takes effect at the next HCLK edge. Reset mid-transfer discards the held transfer.
- Already granted, zero-wait slave: address at cycle N, data completes at N+1 with HREADYOUT=1, so 0 wait states.
- Not granted, arbiter idle, zero-wait slave:
  - N: capture, REQ=1.
  - N+1: grant visible, held address issued.
  - N+2: HREADYOUT=1, so 1 extra wait state.
- While another master's data phase is stalled, the arbiter grant cannot change. PEND persists and REQ_DTCM stays high.
- HREADYOUT and HRESP are combinational from state and output-stage inputs. The holding register and state are registered.

## Test plan
- Grant pre-held (PORT_SEL=PORT_ID), NONSEQ write to 0x2000_0010, zero-wait -> HTRANS_Inputstage=10 in the same cycle, HREADYOUT=1 the next cycle, never PEND.
- PORT_NOSEL=1, NONSEQ read 0x2000_0040 -> REQ_DTCM=1 at N; held address appears at N+1 after grant; HREADYOUT 0 at N+1, 1 at N+2.
- Grant held by DMA with a 4-beat INCR4 burst, SYS PORT_ID=01 issues NONSEQ mid-burst -> stays PEND with HREADYOUT=0 until DMA burst HREADY boundary and grant=01. Held HADDR is unchanged throughout.
- DTCM returns ERROR -> HRESP=1 for two cycles, HREADYOUT 0 then 1. The next master NONSEQ is accepted normally.
- Back-to-back NONSEQ at 0x2000_0000 then 0x2000_0004 with grant held -> DATA→DATA with no IDLE gap, two completions in two cycles.
- Assert HRESET while in PEND -> outputs return to reset values immediately. After release, the stale address is never issued.
